// File: rtl/pe_sequencer_pkg.sv
// Shared definitions for the PE instruction sequencer: opcode and FSM state
// encodings plus program-word field positions.
package pe_sequencer_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 13;
  localparam int unsigned RSV_MSB = 12;
  localparam int unsigned RSV_LSB = 8;
  localparam int unsigned CNT_MSB = 7;
  localparam int unsigned CNT_LSB = 0;

  typedef enum logic [2:0] {
    OP_LOAD   = 3'b000,
    OP_ADD    = 3'b001,
    OP_SUB    = 3'b010,
    OP_MUL    = 3'b100,
    OP_MULADD = 3'b101,
    OP_MULSUB = 3'b110,
    OP_MAX    = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_DRAIN = 2'b10,
    S_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/pe_sequencer_if.sv
// Control, program-load and issue signals between the host and the sequencer.
interface pe_sequencer_if #(
  parameter int unsigned PROG_DEPTH = 16
);
  localparam int unsigned AW = $clog2(PROG_DEPTH);

  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic          start;
  logic          abort;
  logic          stall;
  logic          inst_v;
  logic [2:0]    opcode;
  logic          busy;
  logic          done;

  modport master (
    output prog_we, prog_addr, prog_data, start, abort, stall,
    input  inst_v, opcode, busy, done
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, abort, stall,
    output inst_v, opcode, busy, done
  );
endinterface

// File: rtl/pe_sequencer.sv
// Program-memory driven instruction sequencer: issues each word's opcode a
// repeat-count number of times, drains the downstream pipe, then pulses done.
module pe_sequencer
  import pe_sequencer_pkg::*;
#(
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned PIPE_DELAY = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  pe_sequencer_if.slave  bus
);

  localparam int unsigned AW = $clog2(PROG_DEPTH);
  localparam int unsigned DW = (PIPE_DELAY < 1) ? 1 : $clog2(PIPE_DELAY + 1);

  logic [WORD_W-1:0] mem [PROG_DEPTH];

  state_e        state;
  logic [AW-1:0] pc;
  logic [7:0]    rpt_cnt;
  logic [DW-1:0] drain_cnt;
  logic          inst_v_q;
  logic [2:0]    opcode_q;
  logic          busy_q;
  logic          done_q;

  logic [2:0]    word_op;
  logic [7:0]    word_cnt;
  logic          last_rep;
  logic          last_word;

  // Program memory is not reset; writes are only accepted while idle.
  always_ff @(posedge clk) begin
    if (bus.prog_we && !busy_q)
      mem[bus.prog_addr] <= bus.prog_data;
  end

  always_comb begin
    word_op   = mem[pc][OPC_MSB:OPC_LSB];
    word_cnt  = mem[pc][CNT_MSB:CNT_LSB];
    last_rep  = ((rpt_cnt + 8'd1) == word_cnt);
    last_word = (pc == AW'(PROG_DEPTH - 1));
  end

  // drain_cnt counts inst_v-low cycles already shown, so a zero-count
  // terminator enters DRAIN at 1 while a final issue enters at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      rpt_cnt   <= '0;
      drain_cnt <= '0;
      inst_v_q  <= 1'b0;
      opcode_q  <= OP_LOAD;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      inst_v_q <= 1'b0;
      opcode_q <= OP_LOAD;
      done_q   <= 1'b0;
      if (state != S_IDLE && bus.abort) begin
        state     <= S_IDLE;
        busy_q    <= 1'b0;
        pc        <= '0;
        rpt_cnt   <= '0;
        drain_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start && !bus.abort) begin
              state   <= S_ISSUE;
              busy_q  <= 1'b1;
              pc      <= '0;
              rpt_cnt <= '0;
            end
          end
          S_ISSUE: begin
            if (!bus.stall) begin
              if (word_cnt == 8'd0) begin
                state     <= S_DRAIN;
                drain_cnt <= DW'(1);
              end else begin
                inst_v_q <= 1'b1;
                opcode_q <= word_op;
                if (last_rep) begin
                  rpt_cnt <= '0;
                  if (last_word) begin
                    state     <= S_DRAIN;
                    drain_cnt <= '0;
                  end else begin
                    pc <= pc + AW'(1);
                  end
                end else begin
                  rpt_cnt <= rpt_cnt + 8'd1;
                end
              end
            end
          end
          S_DRAIN: begin
            if (drain_cnt >= DW'(PIPE_DELAY)) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + DW'(1);
            end
          end
          S_DONE: begin
            state     <= S_IDLE;
            busy_q    <= 1'b0;
            drain_cnt <= '0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.inst_v = inst_v_q;
  assign bus.opcode = opcode_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed self-checking bench for pe_sequencer.
module tb_pe_sequencer;
  import pe_sequencer_pkg::*;

  localparam int unsigned PROG_DEPTH = 16;
  localparam int unsigned PIPE_DELAY = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  pe_sequencer_if #(.PROG_DEPTH(PROG_DEPTH)) bus ();

  pe_sequencer #(.PROG_DEPTH(PROG_DEPTH), .PIPE_DELAY(PIPE_DELAY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [2:0] op, input logic [7:0] cnt);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = {op, 5'b10101, cnt};
    tick();
    bus.prog_we   = 1'b0;
  endtask

  task automatic load_basic();
    write_word(4'd0, OP_ADD, 8'd3);
    write_word(4'd1, OP_MUL, 8'd2);
    write_word(4'd2, OP_LOAD, 8'd0);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.inst_v !== 1'b0 || bus.opcode !== 3'b000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: inst_v=%b opcode=%b busy=%b done=%b, expected 0 000 0 0",
               bus.inst_v, bus.opcode, bus.busy, bus.done);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.inst_v !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b inst_v=%b, expected 0 0", bus.busy, bus.inst_v);
    end
  endtask

  task automatic test_basic();
    logic       ev, ed, eb;
    logic [2:0] eo;
    load_basic();
    go();
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) tick();
      ev = (i >= 1 && i <= 5);
      eo = (i >= 1 && i <= 3) ? OP_ADD : (i >= 4 && i <= 5) ? OP_MUL : OP_LOAD;
      ed = (i == 14);
      eb = (i <= 14);
      checks++;
      if (bus.inst_v !== ev || bus.opcode !== eo) begin
        errors++;
        $display("FAIL basic_issue cyc %0d: inst_v=%b opcode=%b, expected %b %b", i, bus.inst_v, bus.opcode, ev, eo);
      end
      checks++;
      if (bus.done !== ed || bus.busy !== eb) begin
        errors++;
        $display("FAIL basic_status cyc %0d: done=%b busy=%b, expected %b %b", i, bus.done, bus.busy, ed, eb);
      end
    end
  endtask

  task automatic test_stall();
    logic       ev, ed, eb;
    logic [2:0] eo;
    int         n_sub = 0;
    write_word(4'd0, OP_SUB, 8'd4);
    write_word(4'd1, OP_LOAD, 8'd0);
    go();
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) tick();
      ev = (i == 1 || i == 2 || i == 5 || i == 6);
      eo = ev ? OP_SUB : OP_LOAD;
      ed = (i == 15);
      eb = (i <= 15);
      if (bus.inst_v === 1'b1 && bus.opcode === OP_SUB) n_sub++;
      checks++;
      if (bus.inst_v !== ev || bus.opcode !== eo || bus.done !== ed || bus.busy !== eb) begin
        errors++;
        $display("FAIL stall_cycle cyc %0d: inst_v=%b opcode=%b done=%b busy=%b, expected %b %b %b %b",
                 i, bus.inst_v, bus.opcode, bus.done, bus.busy, ev, eo, ed, eb);
      end
      bus.stall = (i == 2 || i == 3);
    end
    bus.stall = 1'b0;
    checks++;
    if (n_sub != 4) begin
      errors++;
      $display("FAIL stall_issue_count: got %0d SUB issues, expected 4", n_sub);
    end
  endtask

  task automatic test_full_program();
    logic       ev, ed, eb;
    logic [2:0] eo;
    int         n_iss = 0;
    for (int a = 0; a < 16; a++) write_word(4'(a), OP_MULADD, 8'd1);
    go();
    for (int i = 0; i <= 30; i++) begin
      if (i > 0) tick();
      ev = (i >= 1 && i <= 16);
      eo = ev ? OP_MULADD : OP_LOAD;
      ed = (i == 25);
      eb = (i <= 25);
      if (bus.inst_v === 1'b1) n_iss++;
      checks++;
      if (bus.inst_v !== ev || bus.opcode !== eo || bus.done !== ed || bus.busy !== eb) begin
        errors++;
        $display("FAIL full_cycle cyc %0d: inst_v=%b opcode=%b done=%b busy=%b, expected %b %b %b %b",
                 i, bus.inst_v, bus.opcode, bus.done, bus.busy, ev, eo, ed, eb);
      end
    end
    checks++;
    if (n_iss != 16) begin
      errors++;
      $display("FAIL full_issue_count: got %0d issues, expected 16", n_iss);
    end
  endtask

  task automatic test_max_count();
    int n_iss = 0;
    int n_bad = 0;
    write_word(4'd0, OP_ADD, 8'd255);
    write_word(4'd1, OP_LOAD, 8'd0);
    go();
    for (int i = 1; i <= 265; i++) begin
      tick();
      if (bus.inst_v === 1'b1) n_iss++;
      if (bus.inst_v !== (i <= 255) || bus.done !== (i == 264) || bus.busy !== (i <= 264)) n_bad++;
    end
    checks++;
    if (n_iss != 255) begin
      errors++;
      $display("FAIL max_count_issues: got %0d issues, expected 255", n_iss);
    end
    checks++;
    if (n_bad != 0) begin
      errors++;
      $display("FAIL max_count_timing: %0d cycles off the expected pattern, expected 0", n_bad);
    end
  endtask

  task automatic test_abort();
    int n_v = 0;
    int n_d = 0;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.inst_v !== 1'b0) begin
      errors++;
      $display("FAIL abort_beats_start: busy=%b inst_v=%b, expected 0 0", bus.busy, bus.inst_v);
    end
    write_word(4'd0, OP_MAX, 8'd200);
    go();
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (bus.inst_v !== 1'b1 || bus.opcode !== OP_MAX) n_v++;
    end
    checks++;
    if (n_v != 0) begin
      errors++;
      $display("FAIL abort_pre_issue: %0d of 50 cycles lacked a MAX issue, expected 0", n_v);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if (bus.inst_v !== 1'b0 || bus.opcode !== 3'b000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_stop: inst_v=%b opcode=%b busy=%b done=%b, expected 0 000 0 0",
               bus.inst_v, bus.opcode, bus.busy, bus.done);
    end
    n_v = 0;
    for (int i = 0; i < 250; i++) begin
      tick();
      if (bus.inst_v !== 1'b0) n_v++;
      if (bus.done !== 1'b0) n_d++;
    end
    checks++;
    if (n_v != 0 || n_d != 0) begin
      errors++;
      $display("FAIL abort_quiet: inst_v cycles=%0d done cycles=%0d, expected 0 0", n_v, n_d);
    end
  endtask

  task automatic test_busy_write();
    logic       ev, ed, eb;
    logic [2:0] eo;
    write_word(4'd0, OP_ADD, 8'd2);
    write_word(4'd1, OP_LOAD, 8'd0);
    for (int r = 0; r < 2; r++) begin
      go();
      if (r == 0) begin
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd0;
        bus.prog_data = {OP_SUB, 5'b00000, 8'd3};
      end
      for (int i = 0; i <= 12; i++) begin
        if (i > 0) tick();
        if (i == 1) bus.prog_we = 1'b0;
        ev = (i == 1 || i == 2);
        eo = ev ? OP_ADD : OP_LOAD;
        ed = (i == 11);
        eb = (i <= 11);
        checks++;
        if (bus.inst_v !== ev || bus.opcode !== eo || bus.done !== ed || bus.busy !== eb) begin
          errors++;
          $display("FAIL busy_write run %0d cyc %0d: inst_v=%b opcode=%b done=%b busy=%b, expected %b %b %b %b",
                   r, i, bus.inst_v, bus.opcode, bus.done, bus.busy, ev, eo, ed, eb);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic       ev;
    logic [2:0] eo;
    int         n_d = 0;
    load_basic();
    go();
    tick();
    tick();
    checks++;
    if (bus.inst_v !== 1'b1 || bus.opcode !== OP_ADD) begin
      errors++;
      $display("FAIL midreset_pre: inst_v=%b opcode=%b, expected 1 001", bus.inst_v, bus.opcode);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.inst_v !== 1'b0 || bus.opcode !== 3'b000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: inst_v=%b opcode=%b busy=%b done=%b, expected 0 000 0 0",
               bus.inst_v, bus.opcode, bus.busy, bus.done);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) n_d++;
    end
    checks++;
    if (n_d != 0) begin
      errors++;
      $display("FAIL midreset_no_done: %0d cycles with done or busy, expected 0", n_d);
    end
    go();
    for (int i = 0; i <= 15; i++) begin
      if (i > 0) tick();
      ev = (i >= 1 && i <= 5);
      eo = (i >= 1 && i <= 3) ? OP_ADD : (i >= 4 && i <= 5) ? OP_MUL : OP_LOAD;
      checks++;
      if (bus.inst_v !== ev || bus.opcode !== eo || bus.done !== (i == 14)) begin
        errors++;
        $display("FAIL midreset_rerun cyc %0d: inst_v=%b opcode=%b done=%b, expected %b %b %b",
                 i, bus.inst_v, bus.opcode, bus.done, ev, eo, (i == 14));
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.stall     = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_full_program();
    test_max_count();
    test_abort();
    test_busy_write();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_sequencer.md
PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 SHALL have parameter PROG_DEPTH, default 16, meaning the number of program words (power of two, 4..64).
REQ-002 SHALL have parameter PIPE_DELAY, default 8, meaning the downstream decode-plus-DSP pipeline depth, in cycles, to drain before done.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port prog_we, input, 1, program-memory write strobe.
REQ-006 SHALL have port prog_addr, input, log2(PROG_DEPTH), program write address.
REQ-007 SHALL have port prog_data, input, 16, program word: [15:13] opcode, [12:8] reserved (written, ignored), [7:0] repeat count.
REQ-008 SHALL have port start, input, 1, run request.
REQ-009 SHALL have port abort, input, 1, terminate run.
REQ-010 SHALL have port stall, input, 1, freeze issue.
REQ-011 SHALL have port inst_v, output, 1, instruction-valid to the decoder.
REQ-012 SHALL have port opcode, output, 3, opcode to the decoder.
REQ-013 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-016 IDLE: start=1 and abort=0 SHALL set pc=0 and go to ISSUE; start in any other state SHALL be ignored.
REQ-017 ISSUE, word count==0: SHALL act as end-of-program and go to DRAIN without asserting inst_v.
REQ-018 ISSUE, count N>0: SHALL assert inst_v=1 with opcode=word[15:13] for exactly N non-stalled cycles, then advance pc by 1.
REQ-019 Timing: if start is sampled at edge k, inst_v SHALL first be high after edge k+1 (one fetch cycle); all outputs SHALL be registered.
REQ-020 Consecutive non-zero words SHALL issue back-to-back with no inst_v gap.
REQ-021 Last word: if pc==PROG_DEPTH-1 and its repeats finish, SHALL go to DRAIN; pc SHALL NOT wrap.
REQ-022 stall=1 in ISSUE SHALL force inst_v=0 the next cycle and hold pc and the repeat counter; issue SHALL resume on the cycle after stall drops, with no repeat lost or duplicated.
REQ-023 DRAIN SHALL hold inst_v=0 and opcode=3'b000 for PIPE_DELAY cycles, then go to DONE.
REQ-024 DONE SHALL assert done=1 for exactly one cycle and return to IDLE.
REQ-025 abort=1 in any non-IDLE state SHALL go to IDLE at the next edge with inst_v=0, done=0, and without draining; abort SHALL beat simultaneous start.
REQ-026 opcode SHALL be 3'b000 (LOAD) whenever inst_v=0.
REQ-027 prog_we SHALL write mem[prog_addr]<=prog_data only when busy=0; writes while busy SHALL be dropped.
REQ-028 Program memory SHALL be read combinationally within the sequencer; contents SHALL be undefined until written and SHALL NOT be cleared by rst_n.
REQ-029 The repeat counter SHALL be 8 bits; count 255 SHALL yield 255 issues.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, pc=0, repeat counter=0, drain counter=0, inst_v=0, opcode=3'b000, busy=0, and done=0.
REQ-031 Reset mid-run SHALL discard the run; no done SHALL follow.

Structure
REQ-032 Opcode encodings (LOAD 000, ADD 001, SUB 010, MUL 100, MULADD 101, MULSUB 110, MAX 111), the FSM state encoding, and the program-word field positions SHALL live in the shared parameters include.
REQ-033 The design SHALL be a single module with no sub-modules; the program memory is an inferred register array.

Verification
REQ-034 Program {ADD,3},{MUL,2},{LOAD,0}, then start: SHALL produce inst_v high for 5 consecutive cycles, opcodes 001,001,001,100,100; then 8 idle cycles; then done pulse; busy falls with done.
REQ-035 Program {SUB,4} with stall high for 2 cycles after the 2nd issue: SHALL produce exactly 4 opcode-010 issues, with an inst_v gap of 2 cycles.
REQ-036 All 16 words {MULADD,1}, no terminator: SHALL produce 16 issues, pc stops at 15, then drain and done.
REQ-037 Program {MAX,200}, abort at the 50th issue: SHALL drop inst_v the next cycle, busy=0, and never assert done.
REQ-038 prog_we to addr 0 during a run: SHALL leave the run unchanged; a rerun SHALL show the old word.
REQ-039 rst_n pulsed low mid-ISSUE: SHALL drop outputs to reset values asynchronously, and start after release SHALL rerun from pc 0.
